// File: rtl/radar_pkg.sv
// Shared types and default widths for the radar pixel-window reader/receiver pair.
package radar_pkg;

  localparam int RADAR_ROW_W = 8;
  localparam int RADAR_COL_W = 8;
  localparam int RADAR_CH_W  = 4;
  localparam int RADAR_PIX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RECV,
    ST_DONE
  } rx_state_t;

  typedef struct packed {
    logic range;
    logic len;
    logic ovf;
    logic timeout;
  } rx_status_t;

endpackage

// File: rtl/radar_window_rx_if.sv
// Buffered pixel output stream (valid/ready with end-of-frame marker).
interface radar_window_rx_if #(
  parameter int PIX_W = 16
);
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/radar_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; read data reads as zero while empty.
module radar_pixel_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A write while full is accepted only when the head is leaving in the same cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/radar_window_rx.sv
// Issues a pixel-window command to the reader, buffers the returned frame and reports status.
module radar_window_rx
  import radar_pkg::*;
#(
  parameter int ROW_W      = RADAR_ROW_W,
  parameter int COL_W      = RADAR_COL_W,
  parameter int CH_W       = RADAR_CH_W,
  parameter int PIX_W      = RADAR_PIX_W,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ROW_W-1:0]   cmd_row1,
  input  logic [ROW_W-1:0]   cmd_row2,
  input  logic [COL_W-1:0]   cmd_col1,
  input  logic [COL_W-1:0]   cmd_col2,
  input  logic [CH_W-1:0]    cmd_channel,
  output logic [ROW_W-1:0]   row_idx1,
  output logic [ROW_W-1:0]   row_idx2,
  output logic [COL_W-1:0]   col_idx1,
  output logic [COL_W-1:0]   col_idx2,
  output logic [CH_W-1:0]    channel_num,
  input  logic               data_start,
  input  logic               data_end,
  input  logic [PIX_W-1:0]   pixel_in,
  radar_window_rx_if.master  m,
  output logic               busy,
  output logic               done,
  output logic               err_range,
  output logic               err_len,
  output logic               err_ovf,
  output logic               err_timeout
);
  localparam int CNT_W = ROW_W + COL_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  rx_state_t        state;
  rx_status_t       status;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] win_rows;
  logic [CNT_W-1:0] win_cols;
  logic             accept;
  logic             bad_range;
  logic             capture;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [PIX_W:0]   fifo_rd;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign bad_range = (cmd_row2 < cmd_row1) || (cmd_col2 < cmd_col1);
  assign win_rows  = CNT_W'(cmd_row2 - cmd_row1) + CNT_W'(1);
  assign win_cols  = CNT_W'(cmd_col2 - cmd_col1) + CNT_W'(1);

  // Reader streams gap-free from data_start through data_end, so every RECV cycle carries a pixel.
  assign capture   = ((state == ST_ISSUE) && data_start) || (state == ST_RECV);
  assign count_nxt = (&count) ? count : count + CNT_W'(1);
  assign fifo_pop  = m.m_valid && m.m_ready;

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign err_range   = status.range;
  assign err_len     = status.len;
  assign err_ovf     = status.ovf;
  assign err_timeout = status.timeout;

  assign m.m_valid = !fifo_empty;
  assign m.m_data  = fifo_rd[PIX_W-1:0];
  assign m.m_last  = fifo_rd[PIX_W];

  radar_pixel_fifo #(
    .WIDTH (PIX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data ({data_end, pixel_in}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      status      <= '0;
      timer       <= '0;
      count       <= '0;
      expected    <= '0;
      row_idx1    <= '0;
      row_idx2    <= '0;
      col_idx1    <= '0;
      col_idx2    <= '0;
      channel_num <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (bad_range) begin
              status       <= '0;
              status.range <= 1'b1;
              state        <= ST_DONE;
            end else begin
              row_idx1    <= cmd_row1;
              row_idx2    <= cmd_row2;
              col_idx1    <= cmd_col1;
              col_idx2    <= cmd_col2;
              channel_num <= cmd_channel;
              expected    <= win_rows * win_cols;
              status      <= '0;
              timer       <= '0;
              count       <= '0;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          timer <= timer + TMR_W'(1);
          if (data_start) begin
            count <= count_nxt;
            if (data_end) begin
              status.len <= (count_nxt != expected);
              state      <= ST_DONE;
            end else begin
              state <= ST_RECV;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            status.timeout <= 1'b1;
            state          <= ST_DONE;
          end
        end
        ST_RECV: begin
          count <= count_nxt;
          if (data_end) begin
            status.len <= (count_nxt != expected);
            state      <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (capture && fifo_full && !fifo_pop) status.ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_radar_window_rx.sv
// Scoreboard bench: stimulus queues expected pixels/status, monitors compare on handshakes.
module tb_radar_window_rx;
  import radar_pkg::*;

  localparam int ROW_W      = 8;
  localparam int COL_W      = 8;
  localparam int CH_W       = 4;
  localparam int PIX_W      = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [ROW_W-1:0] cmd_row1 = '0, cmd_row2 = '0;
  logic [COL_W-1:0] cmd_col1 = '0, cmd_col2 = '0;
  logic [CH_W-1:0]  cmd_channel = '0;
  logic [ROW_W-1:0] row_idx1, row_idx2;
  logic [COL_W-1:0] col_idx1, col_idx2;
  logic [CH_W-1:0]  channel_num;
  logic             data_start = 1'b0, data_end = 1'b0;
  logic [PIX_W-1:0] pixel_in = '0;
  logic             busy, done, err_range, err_len, err_ovf, err_timeout;

  radar_window_rx_if #(.PIX_W(PIX_W)) m_if ();

  radar_window_rx #(
    .ROW_W      (ROW_W),
    .COL_W      (COL_W),
    .CH_W       (CH_W),
    .PIX_W      (PIX_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_row1    (cmd_row1),
    .cmd_row2    (cmd_row2),
    .cmd_col1    (cmd_col1),
    .cmd_col2    (cmd_col2),
    .cmd_channel (cmd_channel),
    .row_idx1    (row_idx1),
    .row_idx2    (row_idx2),
    .col_idx1    (col_idx1),
    .col_idx2    (col_idx2),
    .channel_num (channel_num),
    .data_start  (data_start),
    .data_end    (data_end),
    .pixel_in    (pixel_in),
    .m           (m_if.master),
    .busy        (busy),
    .done        (done),
    .err_range   (err_range),
    .err_len     (err_len),
    .err_ovf     (err_ovf),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PIX_W:0] exp_px[$];  // {last, data}
  logic [3:0]     exp_st[$];  // {range, len, ovf, timeout}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output-stream monitor: a transfer is the cycle with m_valid && m_ready.
  always @(negedge clk) begin
    if (!rst && m_if.m_valid && m_if.m_ready) begin
      if (exp_px.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_pixel: got 0x%0h, expected no output", {m_if.m_last, m_if.m_data});
      end else begin
        check("pixel", {15'd0, m_if.m_last, m_if.m_data}, {15'd0, exp_px.pop_front()});
      end
    end
  end

  // Completion monitor: status is compared in the done cycle.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_st.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stray_done: got done=1, expected no completion");
      end else begin
        check("status", {28'd0, err_range, err_len, err_ovf, err_timeout}, {28'd0, exp_st.pop_front()});
      end
    end
  end

  // All driving happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] r1, input logic [7:0] r2,
                          input logic [7:0] c1, input logic [7:0] c2, input logic [3:0] ch);
    int k = 0;
    while (!cmd_ready && k < 50) begin
      tick();
      k++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_row1 = r1; cmd_row2 = r2; cmd_col1 = c1; cmd_col2 = c2; cmd_channel = ch;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_frame(input int n, input logic [15:0] base, input int keep);
    for (int i = 0; i < n && i < keep; i++)
      exp_px.push_back({(i == n - 1) ? 1'b1 : 1'b0, base + 16'(i)});
  endtask

  task automatic send_frame(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      data_start = (i == 0);
      data_end   = (i == n - 1);
      pixel_in   = base + 16'(i);
      tick();
    end
    data_start = 1'b0;
    data_end   = 1'b0;
    pixel_in   = '0;
  endtask

  task automatic wait_idle_and_drain();
    int k = 0;
    while ((busy || m_if.m_valid) && k < 3000) begin
      tick();
      k++;
    end
    tick();
    check("idle_drained", {31'd0, busy | m_if.m_valid}, 32'd0);
    check("scoreboard_empty", exp_px.size() + exp_st.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    m_if.m_ready = 1'b1;

    repeat (3) tick();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_outputs", {25'd0, m_if.m_valid, m_if.m_last, busy, done, err_range, err_len, err_ovf, err_timeout}, 32'd0);
    check("rst_idx", {row_idx1, row_idx2, col_idx1, col_idx2}, 32'd0);
    check("rst_data_ch", {12'd0, channel_num, m_if.m_data}, 32'd0);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // 2x3 window, six pixels, no backpressure
    expect_frame(6, 16'h0010, 6);
    exp_st.push_back(4'b0000);
    send_cmd(8'd2, 8'd3, 8'd5, 8'd7, 4'd3);
    check("idx_latched", {row_idx1, row_idx2, col_idx1, col_idx2}, 32'h0203_0507);
    check("channel_busy", {27'd0, channel_num, busy}, {27'd0, 4'd3, 1'b1});
    send_frame(6, 16'h0010);
    check("done_after_end", {31'd0, done}, 32'd1);
    tick();
    check("ready_after_done", {30'd0, done, cmd_ready}, 32'd1);
    wait_idle_and_drain();

    // single-pixel frame: start and end together
    expect_frame(1, 16'hABCD, 1);
    exp_st.push_back(4'b0000);
    send_cmd(8'd4, 8'd4, 8'd9, 8'd9, 4'd0);
    send_frame(1, 16'hABCD);
    check("single_done", {31'd0, done}, 32'd1);
    wait_idle_and_drain();

    // 2x2 window but five pixels arrive
    expect_frame(5, 16'h0020, 5);
    exp_st.push_back(4'b0100);
    send_cmd(8'd0, 8'd1, 8'd0, 8'd1, 4'd1);
    send_frame(5, 16'h0020);
    wait_idle_and_drain();

    // 4x8 window with the sink stalled: only FIFO_DEPTH pixels survive, last one dropped
    m_if.m_ready = 1'b0;
    expect_frame(32, 16'h0100, FIFO_DEPTH);
    exp_st.push_back(4'b0010);
    send_cmd(8'd0, 8'd3, 8'd0, 8'd7, 4'd2);
    send_frame(32, 16'h0100);
    tick();
    check("ovf_held_valid", {31'd0, m_if.m_valid}, 32'd1);
    m_if.m_ready = 1'b1;
    wait_idle_and_drain();

    // no data_start: done arrives TIMEOUT+1 cycles counting the accept edge
    exp_st.push_back(4'b0001);
    send_cmd(8'd1, 8'd2, 8'd1, 8'd2, 4'd0);
    lat = 1;
    while (!done && lat < TIMEOUT + 20) begin
      tick();
      lat++;
    end
    check("timeout_latency", lat, TIMEOUT + 1);
    wait_idle_and_drain();

    // row range inverted: immediate completion, index outputs untouched
    exp_st.push_back(4'b1000);
    send_cmd(8'd3, 8'd1, 8'd0, 8'd0, 4'd9);
    check("range_done", {30'd0, done, err_range}, 32'd3);
    check("range_idx_kept", {row_idx1, row_idx2, col_idx1, col_idx2}, 32'h0102_0102);
    wait_idle_and_drain();

    // column range inverted
    exp_st.push_back(4'b1000);
    send_cmd(8'd0, 8'd0, 8'd5, 8'd4, 4'd0);
    wait_idle_and_drain();

    // frame markers while idle are ignored
    send_frame(3, 16'h0700);
    wait_idle_and_drain();

    // reset on the third pixel of a 16-pixel frame
    m_if.m_ready = 1'b0;
    send_cmd(8'd0, 8'd3, 8'd0, 8'd3, 4'd5);
    for (int i = 0; i < 16; i++) begin
      data_start = (i == 0);
      data_end   = (i == 15);
      pixel_in   = 16'h0300 + 16'(i);
      rst        = (i == 2);
      tick();
    end
    data_start = 1'b0; data_end = 1'b0; pixel_in = '0;
    check("abort_outputs", {25'd0, m_if.m_valid, m_if.m_last, busy, done, err_range, err_len, err_ovf, err_timeout}, 32'd0);
    check("abort_idx", {row_idx1, row_idx2, col_idx1, col_idx2}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    m_if.m_ready = 1'b1;

    // clean command after the abort
    expect_frame(2, 16'h0055, 2);
    exp_st.push_back(4'b0000);
    send_cmd(8'd1, 8'd1, 8'd2, 8'd3, 4'd7);
    send_frame(2, 16'h0055);
    wait_idle_and_drain();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
